iter_divider: RTL and testbench
===============================

// Module: iter_divider
// PURPOSE
//  Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the
//  subtract-based inverse of the combinational adder datapath, using one trial subtraction per cycle.
//  It sits beside the ALU in EX. The core stalls while busy=1 and captures result on done.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=4)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  start      in   1      request; accepted only when busy=0
//  op         in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU (= funct3[1:0])
//  a          in   WIDTH  dividend, sampled on accepted start
//  b          in   WIDTH  divisor, sampled on accepted start
//  busy       out  1      operation in flight
//  done       out  1      one-cycle pulse; result valid this cycle and held after
//  result     out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)
//  abort      in   1      only with DIV_ABORT_EN
// BEHAVIOUR
//  Reset (rst_n=0, any time, incl. mid-operation)
//   - State -> IDLE. busy=0, done=0, result=0, all internal regs cleared.
//   - No done is produced for an operation that reset interrupts.
//  State machine
//   - FSM states: IDLE, CALC, FIX, DONE.
//   - IDLE: start=1 accepts the request at edge E0. a, b and op are latched.
//     - Signed ops: take absolute values; record quotient sign (a^b MSB) and remainder sign (a MSB).
//     - Normal case -> CALC. Special case -> DONE.
//   - CALC runs exactly WIDTH cycles. Each cycle:
//     - shift {rem,quo} left by 1;
//     - trial = rem - divisor, computed (WIDTH+1) bits wide;
//     - if trial is non-negative: rem = trial and quo LSB = 1; otherwise quo LSB = 0.
//     - Iteration counter counts 0..WIDTH-1, then -> FIX.
//   - FIX: negate quotient and/or remainder per the recorded signs (signed ops only).
//     Load result per op, then -> DONE.
//   - DONE: done=1 for exactly one cycle, then -> IDLE.
//  Timing
//   - busy=1 from the cycle after E0 up to and including the DONE cycle.
//   - Latency, E0 to the done cycle: WIDTH+2 cycles normal; 1 cycle special.
//  Special cases (detected at E0, no iteration)
//   - Divide by zero (b=0): quotient = all ones; remainder = a. Applies signed and unsigned.
//   - Signed overflow (DIV/REM, a=100..0, b=all ones): quotient = a; remainder = 0.
//  Boundary rules
//   - start while busy=1: ignored, with no effect on the in-flight operation.
//   - start in the DONE cycle: ignored (busy=1 in that cycle).
//   - a, b and op may change freely after E0.
//   - result holds its value until the next done. It never shows intermediate values.
//   - Any WIDTH-bit value is legal. Arithmetic is two's complement; -2^(WIDTH-1) magnitude
//     uses the (WIDTH+1)-bit trial path with no loss.
// CONFIGURATION
//  DIV_ABORT_EN defined:
//   - Adds the abort port.
//   - abort=1 while busy=1 and state!=DONE: FSM returns to IDLE at the next edge.
//     busy=0 next cycle, no done, result unchanged.
//   - abort in IDLE or DONE: no effect.
//   - abort and start in the same IDLE cycle: start wins.
//  DIV_ABORT_EN undefined:
//   - No abort port, no abort logic. Behaviour otherwise identical.
// TESTING (WIDTH=32)
//  1. DIVU a=100 b=7 -> done after 34 cycles, result=0000000E; REMU same operands -> 00000002.
//  2. DIV a=FFFFFFF9 (-7) b=2 -> FFFFFFFD; REM -> FFFFFFFF; DIV a=7 b=FFFFFFFE -> FFFFFFFD.
//  3. DIVU a=5 b=0 -> FFFFFFFF; REM a=FFFFFFFB b=0 -> FFFFFFFB; done 1 cycle after start.
//  4. DIV a=80000000 b=FFFFFFFF -> 80000000; REM -> 00000000; done 1 cycle after start.
//  5. Start DIVU 100/7, pulse start with 9/3 at cycle 5 -> ignored, result=0000000E.
//     Then drop rst_n mid-op -> busy=0, done=0, result=0 immediately.
//  6. Reference check: 200 random a/b/op vs $signed/$unsigned / and %, with b=0 and overflow
//     handled per the special-case rules. With DIV_ABORT_EN: abort at cycle 10 -> no done,
//     and the next op is still correct.

Source files
------------

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// One trial subtraction per cycle. Divide-by-zero and signed overflow finish
// in one cycle without iterating.
// Optional feature: define DIV_ABORT_EN to add the abort port, which cancels
// an in-flight operation.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef DIV_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             is_rem_q, is_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] min_neg;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Operand conditioning and the (WIDTH+1)-bit trial subtraction. The shifted
  // remainder is below twice the divisor, so trial[WIDTH] is a reliable sign.
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign abs_a     = a_neg ? -a : a;
  assign abs_b     = b_neg ? -b : b;
  assign min_neg   = {1'b1, {(WIDTH-1){1'b0}}};
  assign shifted   = {rem_q, quo_q[WIDTH-1]};
  assign trial     = shifted - {1'b0, div_q};
  assign q_fix     = q_neg_q ? -quo_q : quo_q;
  assign r_fix     = r_neg_q ? -rem_q : rem_q;

  // Next-state logic for the FSM and the shift/subtract datapath.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    is_rem_d = is_rem_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_rem_d = op[1];
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          busy_d   = 1'b1;
          if (b == '0) begin
            result_d = op[1] ? a : '1;
            state_d  = DONE;
            done_d   = 1'b1;
          end else if (is_signed && (a == min_neg) && (b == '1)) begin
            result_d = op[1] ? '0 : a;
            state_d  = DONE;
            done_d   = 1'b1;
          end else begin
            rem_d   = '0;
            quo_d   = abs_a;
            div_d   = abs_b;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        result_d = is_rem_q ? r_fix : q_fix;
        state_d  = DONE;
        done_d   = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
`ifdef DIV_ABORT_EN
    if (abort && ((state_q == CALC) || (state_q == FIX))) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
`endif
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_rem_q <= is_rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: self-checking bench for iter_divider (WIDTH=32) with
// directed cases and randomized operations against an arithmetic model.
// Define DIV_ABORT_EN to also exercise the abort port.
module tb_iter_divider;

   localparam int W = 32;
   localparam logic [31:0] MIN_NEG = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   logic clk;
   logic rst_n;
   logic start;
   logic [1:0] op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic busy;
   logic done;
   logic [W-1:0] result;
`ifdef DIV_ABORT_EN
   logic abort;
`endif

   int total;
   int bad;

   iter_divider #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
`ifdef DIV_ABORT_EN
      .result (result),
      .abort  (abort)
`else
      .result (result)
`endif
   );

   // Free-running clock with a 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Architectural result of an RV32M divide/remainder, from plain arithmetic.
   function automatic logic [31:0] refModel(input logic [1:0] fop, input logic [31:0] fa, input logic [31:0] fb);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = fa;
      sb = fb;
      if (fb == 32'd0) return fop[1] ? fa : ALL_ONES;
      if (!fop[0] && fa == MIN_NEG && fb == ALL_ONES) return fop[1] ? 32'd0 : fa;
      case (fop)
         2'b00: return sa / sb;
         2'b01: return fa / fb;
         2'b10: return sa % sb;
         default: return fa % fb;
      endcase
   endfunction

   function automatic int refLatency(input logic [1:0] fop, input logic [31:0] fa, input logic [31:0] fb);
      if (fb == 32'd0) return 1;
      if (!fop[0] && fa == MIN_NEG && fb == ALL_ONES) return 1;
      return W + 2;
   endfunction

   // Issue one operation, optionally pulse a stray start at cycle intrude,
   // then check latency, result, busy, hold and the ignored start in DONE.
   task automatic applyStimulus(input logic [1:0] sop, input logic [31:0] sa, input logic [31:0] sb,
                                input logic [31:0] expRes, input int expLat, input int intrude);
      int lat;
      logic held;
      logic [31:0] prevResult;
      prevResult = result;
      held = 1'b1;
      op = sop;
      a = sa;
      b = sb;
      start = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      start = 1'b0;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
      while (done !== 1'b1 && lat < 60) begin
         if (result !== prevResult) held = 1'b0;
         if (lat == intrude) begin
            start = 1'b1;
            op = 2'b01;
            a = 32'd9;
            b = 32'd3;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      checkOutput("done_seen", {31'd0, done}, 32'd1);
      checkOutput("latency", lat, expLat);
      checkOutput("result", result, expRes);
      checkOutput("busy_in_done", {31'd0, busy}, 32'd1);
      checkOutput("result_held_in_flight", {31'd0, held}, 32'd1);
      start = 1'b1;
      op = 2'b01;
      a = 32'd9;
      b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("done_one_pulse", {31'd0, done}, 32'd0);
      checkOutput("idle_after_done", {31'd0, busy}, 32'd0);
      checkOutput("result_kept", result, expRes);
   endtask

   // Top-level sequence: reset, directed cases, reset mid-op, abort, random.
   initial begin
      logic [1:0] rop;
      logic [31:0] ra;
      logic [31:0] rb;
      int sel;
      int noDone;
      logic [31:0] keep;
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      start = 1'b0;
      op = 2'b00;
      a = '0;
      b = '0;
`ifdef DIV_ABORT_EN
      abort = 1'b0;
`endif
      #12;
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_result", result, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus(2'b01, 32'd100, 32'd7, 32'h0000_000E, 34, 0);
      applyStimulus(2'b11, 32'd100, 32'd7, 32'h0000_0002, 34, 0);
      applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
      applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
      applyStimulus(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0);
      applyStimulus(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
      applyStimulus(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0);
      applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
      applyStimulus(2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 34, 0);
      applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 0);
      applyStimulus(2'b01, 32'd100, 32'd7, 32'h0000_000E, 34, 5);

      start = 1'b1;
      op = 2'b01;
      a = 32'd100;
      b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("midop_reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("midop_reset_done", {31'd0, done}, 32'd0);
      checkOutput("midop_reset_result", result, 32'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 0);

`ifdef DIV_ABORT_EN
      keep = result;
      start = 1'b1;
      op = 2'b01;
      a = 32'd1000;
      b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      noDone = 1;
      repeat (40) begin
         if (done === 1'b1) noDone = 0;
         @(posedge clk); #1;
      end
      checkOutput("abort_no_done", noDone, 1);
      checkOutput("abort_result_kept", result, keep);
      applyStimulus(2'b01, 32'd1000, 32'd3, 32'd333, 34, 0);
`else
      keep = '0;
      noDone = 0;
`endif

      for (int i = 0; i < 200; i++) begin
         rop = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 9);
         ra = $urandom;
         rb = $urandom;
         if (sel == 0) rb = 32'd0;
         else if (sel == 1) begin
            ra = MIN_NEG;
            rb = ALL_ONES;
         end else if (sel == 2) rb = $urandom_range(1, 15);
         else if (sel == 3) rb = -($urandom_range(1, 15));
         applyStimulus(rop, ra, rb, refModel(rop, ra, rb), refLatency(rop, ra, rb), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
